texture_load_controller: RTL and testbench

Sequences uploads of texture data from the command stream into the texel memory read by the texture mapping unit. It accepts one load command (start word address, pixel count) and unpacks command-stream beats into one PIXEL_WIDTH texel write per clock. It raises a lock flag so the render scheduler holds off TMU sampling while the texture is being overwritten. It sits between the command parser and the write port of the texel memory.

---
 rtl/texture_load_controller_pkg.sv | 33 +++
 rtl/texture_load_controller_if.sv | 38 +++
 rtl/texture_beat_unpacker.sv | 62 ++++++
 rtl/texture_load_controller.sv | 166 ++++++++++++++++
 tb/tb_texture_load_controller.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/texture_load_controller_pkg.sv
// Shared definitions for the texture load controller: FSM state encoding,
// lanes-per-beat derivation and the command descriptor layout.
package texture_load_controller_pkg;

    localparam int DEF_CMD_STREAM_WIDTH = 64;
    localparam int DEF_PIXEL_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH       = 17;

    // Command descriptor as packed by the parser: {size, addr}
    localparam int CMD_ADDR_LSB = 0;
    localparam int CMD_SIZE_LSB = DEF_ADDR_WIDTH;
    localparam int CMD_SIZE_W   = DEF_ADDR_WIDTH + 1;
    localparam int CMD_DESC_W   = CMD_SIZE_LSB + CMD_SIZE_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_UNPACK = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } load_state_e;

    // Texels carried by one command-stream beat
    function automatic int lanes_per_beat(input int cmd_w, input int pix_w);
        return cmd_w / pix_w;
    endfunction

    // Width of a lane index; never below one bit
    function automatic int lane_idx_width(input int ppb);
        return (ppb > 1) ? $clog2(ppb) : 1;
    endfunction

endpackage

// File: rtl/texture_load_controller_if.sv
// Command, stream and texel-memory signals of the texture load controller.
// master = command parser / stream source side, slave = the controller.
interface texture_load_controller_if #(
    parameter int CMD_STREAM_WIDTH = texture_load_controller_pkg::DEF_CMD_STREAM_WIDTH,
    parameter int PIXEL_WIDTH      = texture_load_controller_pkg::DEF_PIXEL_WIDTH,
    parameter int ADDR_WIDTH       = texture_load_controller_pkg::DEF_ADDR_WIDTH
);
    logic                        s_cmd_valid;
    logic                        s_cmd_ready;
    logic [ADDR_WIDTH-1:0]       s_cmd_addr;
    logic [ADDR_WIDTH:0]         s_cmd_size;
    logic                        s_axis_tvalid;
    logic                        s_axis_tready;
    logic [CMD_STREAM_WIDTH-1:0] s_axis_tdata;
    logic                        s_axis_tlast;
    logic                        mem_wr_en;
    logic [ADDR_WIDTH-1:0]       mem_wr_addr;
    logic [PIXEL_WIDTH-1:0]      mem_wr_data;
    logic                        tex_lock;
    logic                        done;
    logic                        error;

    modport master (
        output s_cmd_valid, s_cmd_addr, s_cmd_size,
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        input  s_cmd_ready, s_axis_tready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  tex_lock, done, error
    );

    modport slave (
        input  s_cmd_valid, s_cmd_addr, s_cmd_size,
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        output s_cmd_ready, s_axis_tready,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output tex_lock, done, error
    );
endinterface

// File: rtl/texture_beat_unpacker.sv
// Holds one command-stream beat and walks through its texel lanes.
// emit_data is the lane that becomes current after this clock edge, so the
// parent can register it straight into the memory write port.
module texture_beat_unpacker
    import texture_load_controller_pkg::*;
#(
    parameter int CMD_STREAM_WIDTH = DEF_CMD_STREAM_WIDTH,
    parameter int PIXEL_WIDTH      = DEF_PIXEL_WIDTH
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        advance,
    input  logic [CMD_STREAM_WIDTH-1:0] tdata,
    input  logic                        tlast,
    output logic [PIXEL_WIDTH-1:0]      emit_data,
    output logic                        last_lane,
    output logic                        held_tlast
);
    localparam int PPB    = lanes_per_beat(CMD_STREAM_WIDTH, PIXEL_WIDTH);
    localparam int LANE_W = lane_idx_width(PPB);
    localparam logic [LANE_W-1:0] LAST_IDX = LANE_W'(PPB - 1);
    localparam logic [LANE_W-1:0] LANE_ONE = LANE_W'(1);

    logic [CMD_STREAM_WIDTH-1:0] beat_q, beat_d, beat_shift;
    logic [LANE_W-1:0]           lane_q, lane_d;
    logic                        tlast_q, tlast_d;

    // The beat is kept as a shift register: the current lane sits in the LSBs
    always_comb begin
        beat_shift = beat_q >> PIXEL_WIDTH;
        beat_d     = beat_q;
        lane_d     = lane_q;
        tlast_d    = tlast_q;
        if (load) begin
            beat_d  = tdata;
            lane_d  = '0;
            tlast_d = tlast;
        end else if (advance) begin
            beat_d = beat_shift;
            lane_d = lane_q + LANE_ONE;
        end
        emit_data = load ? tdata[PIXEL_WIDTH-1:0] : beat_shift[PIXEL_WIDTH-1:0];
    end

    // Beat, lane index and tlast storage
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            beat_q  <= '0;
            lane_q  <= '0;
            tlast_q <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            lane_q  <= lane_d;
            tlast_q <= tlast_d;
        end
    end

    assign last_lane  = (lane_q == LAST_IDX);
    assign held_tlast = tlast_q;

endmodule

// File: rtl/texture_load_controller.sv
// Texture load controller: accepts a load command, unpacks stream beats into
// one texel write per clock, and locks TMU sampling while the upload runs.
// mem_wr_* show the texel written in the current cycle; addr_q / rem_q track
// the next texel to be issued.
module texture_load_controller
    import texture_load_controller_pkg::*;
#(
    parameter int CMD_STREAM_WIDTH = DEF_CMD_STREAM_WIDTH,
    parameter int PIXEL_WIDTH      = DEF_PIXEL_WIDTH,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH
) (
    input  logic                     aclk,
    input  logic                     reset,
    texture_load_controller_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);

    load_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH:0]    rem_q, rem_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [PIXEL_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   wr_en_q, wr_en_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   lock_q, lock_d;

    logic                   emit;
    logic                   up_load, up_advance;
    logic                   up_last_lane, up_held_tlast;
    logic [PIXEL_WIDTH-1:0] up_emit_data;
    logic                   cmd_ready, beat_ready, cmd_hs, beat_hs, rem_zero;

    texture_beat_unpacker #(
        .CMD_STREAM_WIDTH (CMD_STREAM_WIDTH),
        .PIXEL_WIDTH      (PIXEL_WIDTH)
    ) u_unpacker (
        .aclk       (aclk),
        .reset      (reset),
        .load       (up_load),
        .advance    (up_advance),
        .tdata      (bus.s_axis_tdata),
        .tlast      (bus.s_axis_tlast),
        .emit_data  (up_emit_data),
        .last_lane  (up_last_lane),
        .held_tlast (up_held_tlast)
    );

    // Ready flags decode flopped state only; in UNPACK a new beat is taken
    // just as the last needed lane of the held beat is being written.
    assign rem_zero   = (rem_q == '0);
    assign cmd_ready  = (state_q == ST_IDLE) && !reset;
    assign beat_ready = (state_q == ST_LOAD) || (state_q == ST_DRAIN) ||
                        ((state_q == ST_UNPACK) && up_last_lane && !rem_zero && !up_held_tlast);
    assign cmd_hs     = cmd_ready && bus.s_cmd_valid;
    assign beat_hs    = beat_ready && bus.s_axis_tvalid;

    // Next-state, counters and the registered write port
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        err_d      = err_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        emit       = 1'b0;
        up_load    = 1'b0;
        up_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    addr_d  = bus.s_cmd_addr;
                    rem_d   = bus.s_cmd_size;
                    err_d   = 1'b0;
                    state_d = (bus.s_cmd_size == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat_hs) begin
                    up_load = 1'b1;
                    emit    = 1'b1;
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                if (rem_zero) begin
                    state_d = up_held_tlast ? ST_DONE : ST_DRAIN;
                end else if (up_last_lane) begin
                    if (up_held_tlast) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (beat_hs) begin
                        up_load = 1'b1;
                        emit    = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    up_advance = 1'b1;
                    emit       = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (beat_hs && bus.s_axis_tlast) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = up_emit_data;
            addr_d    = addr_q + ADDR_ONE;
            rem_d     = rem_q - REM_ONE;
        end

        done_d = (state_d == ST_DONE);
        lock_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            lock_q    <= lock_d;
        end
    end

    assign bus.s_cmd_ready   = cmd_ready;
    assign bus.s_axis_tready = beat_ready;
    assign bus.mem_wr_en     = wr_en_q;
    assign bus.mem_wr_addr   = wr_addr_q;
    assign bus.mem_wr_data   = wr_data_q;
    assign bus.tex_lock      = lock_q;
    assign bus.done          = done_q;
    assign bus.error         = err_q;

endmodule

// File: tb/tb_texture_load_controller.sv
// Scoreboard bench for texture_load_controller: expected texel writes are
// queued when an upload is started and compared as the DUT writes them.
module tb_texture_load_controller;
    localparam int CW  = 64;
    localparam int PW  = 32;
    localparam int AW  = 17;
    localparam int PPB = CW / PW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
    } wr_t;

    logic aclk  = 1'b0;
    logic reset = 1'b1;
    always #5 aclk = ~aclk;

    texture_load_controller_if #(.CMD_STREAM_WIDTH(CW), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus();

    texture_load_controller #(.CMD_STREAM_WIDTH(CW), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .aclk  (aclk),
        .reset (reset),
        .bus   (bus)
    );

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_count, done_count, first_wr_cyc, last_wr_cyc, done_cyc, first_hs_cyc;
    logic [CW-1:0] beats[8];

    always @(posedge aclk) cyc <= cyc + 1;

    // Write monitor / scoreboard and done observer
    always @(negedge aclk) begin
        if (!reset && bus.mem_wr_en) begin
            if (wr_count == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required=no write", bus.mem_wr_addr, bus.mem_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.mem_wr_addr !== mon_e.addr || bus.mem_wr_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL texel_write got %h@%h required %h@%h",
                             bus.mem_wr_data, bus.mem_wr_addr, mon_e.data, mon_e.addr);
                end
            end
        end
        if (!reset && bus.done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        wr_count     = 0;
        done_count   = 0;
        first_wr_cyc = -1;
        last_wr_cyc  = -1;
        done_cyc     = -1;
        first_hs_cyc = -1;
        exp_q.delete();
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [AW:0] s);
        int n;
        @(negedge aclk);
        bus.s_cmd_valid = 1'b1;
        bus.s_cmd_addr  = a;
        bus.s_cmd_size  = s;
        n = 0;
        while (!bus.s_cmd_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!bus.s_cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept s_cmd_ready=%b required=1 within 50 cycles", bus.s_cmd_ready);
        end
        @(posedge aclk);
        #1;
        bus.s_cmd_valid = 1'b0;
    endtask

    task automatic send_beats(input int nb);
        int n;
        for (int i = 0; i < nb; i++) begin
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = beats[i];
            bus.s_axis_tlast  = (i == nb - 1);
            n = 0;
            @(negedge aclk);
            while (!bus.s_axis_tready && n < 40) begin
                @(negedge aclk);
                n++;
            end
            if (!bus.s_axis_tready) begin
                checks++;
                errors++;
                $display("FAIL beat_accept beat %0d tready=%b required=1 within 40 cycles", i, bus.s_axis_tready);
            end
            @(posedge aclk);
            #1;
            if (i == 0) first_hs_cyc = cyc;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    // One complete upload with tvalid held high; tlast on the final beat
    task automatic run_upload(input string name, input logic [AW-1:0] a, input int size, input int nb);
        int            avail, nwr, n;
        logic          overrun, exp_err;
        logic [CW-1:0] b;
        logic [AW-1:0] wa;
        avail   = nb * PPB;
        nwr     = (size < avail) ? size : avail;
        overrun = (nb > (size + PPB - 1) / PPB);
        exp_err = (size > avail) || overrun;
        clear_obs();
        for (int k = 0; k < nwr; k++) begin
            b  = beats[k / PPB];
            wa = a + AW'(k);
            exp_q.push_back('{addr: wa, data: b[(k % PPB) * PW +: PW]});
        end

        send_cmd(a, (AW + 1)'(size));
        checks++;
        if (bus.s_axis_tready !== 1'b1 || bus.tex_lock !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_latency tready=%b tex_lock=%b required 1 1", name, bus.s_axis_tready, bus.tex_lock);
        end

        send_beats(nb);

        n = 0;
        while (done_count == 0 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        repeat (3) @(negedge aclk);

        checks++;
        if (done_count != 1) begin
            errors++;
            $display("FAIL %s done_pulses got %0d required 1", name, done_count);
        end
        checks++;
        if (wr_count != nwr) begin
            errors++;
            $display("FAIL %s write_count got %0d required %0d", name, wr_count, nwr);
        end
        checks++;
        if (bus.error !== exp_err) begin
            errors++;
            $display("FAIL %s error got %b required %b", name, bus.error, exp_err);
        end
        if (nwr > 0) begin
            checks++;
            if (first_wr_cyc != first_hs_cyc) begin
                errors++;
                $display("FAIL %s lane0_latency write cycle %0d required %0d", name, first_wr_cyc, first_hs_cyc);
            end
            checks++;
            if (last_wr_cyc - first_wr_cyc != nwr - 1) begin
                errors++;
                $display("FAIL %s write_span got %0d cycles required %0d", name, last_wr_cyc - first_wr_cyc, nwr - 1);
            end
            if (!overrun) begin
                checks++;
                if (done_cyc != last_wr_cyc + 1) begin
                    errors++;
                    $display("FAIL %s done_timing done cycle %0d required %0d", name, done_cyc, last_wr_cyc + 1);
                end
            end
        end
        checks++;
        if (bus.tex_lock !== 1'b0 || bus.s_cmd_ready !== 1'b1 || bus.s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after lock=%b cmd_ready=%b tready=%b required 0 1 0",
                     name, bus.tex_lock, bus.s_cmd_ready, bus.s_axis_tready);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.s_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd_ready got %b required 0", bus.s_cmd_ready);
        end
        checks++;
        if ({bus.s_axis_tready, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.tex_lock, bus.done, bus.error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs tready=%b wr_en=%b addr=%h data=%h lock=%b done=%b error=%b required all 0",
                     bus.s_axis_tready, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.tex_lock, bus.done, bus.error);
        end
        repeat (2) @(negedge aclk);
        reset = 1'b0;
        @(negedge aclk);
        checks++;
        if (bus.s_cmd_ready !== 1'b1 || bus.tex_lock !== 1'b0) begin
            errors++;
            $display("FAIL reset_release cmd_ready=%b lock=%b required 1 0", bus.s_cmd_ready, bus.tex_lock);
        end
    endtask

    task automatic test_aligned();
        beats[0] = 64'h22222222_11111111;
        beats[1] = 64'h44444444_33333333;
        run_upload("aligned", 17'h00100, 4, 2);
    endtask

    task automatic test_partial_last_beat();
        beats[0] = {$urandom, $urandom};
        beats[1] = {$urandom, $urandom};
        run_upload("partial", 17'h00230, 3, 2);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 3; i++) beats[i] = {$urandom, $urandom};
        run_upload("overrun", 17'h00400, 2, 3);
    endtask

    task automatic test_underrun();
        beats[0] = {$urandom, $urandom};
        beats[1] = {$urandom, $urandom};
        run_upload("underrun", 17'h00800, 6, 2);
    endtask

    task automatic test_addr_wrap();
        beats[0] = 64'hBBBBBBBB_AAAAAAAA;
        run_upload("wrap", 17'h1FFFF, 2, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
        run_upload("back_to_back", 17'h01000, 8, 4);
    endtask

    task automatic test_zero_size();
        clear_obs();
        send_cmd(17'h00055, '0);
        checks++;
        if (bus.done !== 1'b1 || bus.s_axis_tready !== 1'b0 || bus.tex_lock !== 1'b1) begin
            errors++;
            $display("FAIL zero_size_done done=%b tready=%b lock=%b required 1 0 1", bus.done, bus.s_axis_tready, bus.tex_lock);
        end
        repeat (3) @(negedge aclk);
        checks++;
        if (wr_count != 0 || done_count != 1 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL zero_size_after writes=%0d dones=%0d error=%b required 0 1 0", wr_count, done_count, bus.error);
        end
    endtask

    task automatic test_reset_mid_unpack();
        int n;
        clear_obs();
        beats[0] = {$urandom, $urandom};
        send_cmd(17'h00040, 18'd8);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = beats[0];
        bus.s_axis_tlast  = 1'b0;
        n = 0;
        @(negedge aclk);
        while (!bus.s_axis_tready && n < 40) begin
            @(negedge aclk);
            n++;
        end
        @(posedge aclk);
        #1;
        bus.s_axis_tvalid = 1'b0;
        checks++;
        if (bus.mem_wr_en !== 1'b1 || bus.mem_wr_addr !== 17'h00040 || bus.mem_wr_data !== beats[0][PW-1:0]) begin
            errors++;
            $display("FAIL mid_reset_first_write en=%b addr=%h data=%h required 1 00040 %h",
                     bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, beats[0][PW-1:0]);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.mem_wr_en, bus.s_axis_tready, bus.tex_lock, bus.done, bus.s_cmd_ready, bus.error} !== 6'b0 ||
            bus.mem_wr_addr !== '0 || bus.mem_wr_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs en=%b tready=%b lock=%b done=%b cmd_ready=%b error=%b addr=%h data=%h required all 0",
                     bus.mem_wr_en, bus.s_axis_tready, bus.tex_lock, bus.done, bus.s_cmd_ready, bus.error,
                     bus.mem_wr_addr, bus.mem_wr_data);
        end
        repeat (2) @(negedge aclk);
        reset = 1'b0;
        repeat (3) @(negedge aclk);
        checks++;
        if (wr_count != 0 || done_count != 0 || bus.s_cmd_ready !== 1'b1 || bus.tex_lock !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after writes=%0d dones=%0d cmd_ready=%b lock=%b required 0 0 1 0",
                     wr_count, done_count, bus.s_cmd_ready, bus.tex_lock);
        end
    endtask

    initial begin
        bus.s_cmd_valid   = 1'b0;
        bus.s_cmd_addr    = '0;
        bus.s_cmd_size    = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        clear_obs();

        test_reset();
        test_aligned();
        test_partial_last_beat();
        test_overrun();
        test_underrun();
        test_zero_size();
        test_addr_wrap();
        test_back_to_back();
        test_reset_mid_unpack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
